// File: rtl/life_datapath.sv
// life_datapath -- datapath of an 8x8 Conway Game-of-Life engine.
//
// Holds the 64-cell board and updates it once per clock according to mode:
// hold, edit (write one cell at an auto-advancing cursor), play (advance one
// generation unless stopped) or clear. Cell (row r, col c) is grid[8*r + c].
//
// Ports:
//   clk   in   1   system clock, all state changes on the rising edge
//   rst   in   1   synchronous active-high reset (grid and cursor to 0)
//   mode  in   2   00 hold, 01 edit, 10 play, 11 clear
//   btn0  in   1   edit: write live cell at cursor, advance cursor
//   btn1  in   1   edit: write dead cell at cursor, advance cursor
//   stop  in   1   play: freeze the board while high
//   grid  out  64  registered board, 1 = alive
module life_datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic        btn0,
    input  logic        btn1,
    input  logic        stop,
    output logic [63:0] grid
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_EDIT  = 2'b01,
        MODE_PLAY  = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_t;

    mode_t       w_mode;
    logic [63:0] r_grid;
    logic [5:0]  r_cursor;
    logic [63:0] w_next;
    // Board surrounded by a ring of permanently dead cells; padded cell
    // (R, C) with R,C in 0..9 lives at bit 10*R + C. This keeps every
    // neighbour lookup a constant index with no edge special cases.
    logic [99:0] w_pad;

    assign w_mode = mode_t'(mode);
    assign grid   = r_grid;

    for (genvar k = 0; k < 10; k++) begin : gen_pad_rows
        assign w_pad[k]      = 1'b0;
        assign w_pad[90 + k] = 1'b0;
    end

    for (genvar k = 1; k < 9; k++) begin : gen_pad_cols
        assign w_pad[10 * k]     = 1'b0;
        assign w_pad[10 * k + 9] = 1'b0;
    end

    for (genvar r = 0; r < 8; r++) begin : gen_row
        for (genvar c = 0; c < 8; c++) begin : gen_col
            localparam int P = (r + 1) * 10 + (c + 1);
            logic [3:0] w_n;

            assign w_pad[P] = r_grid[8 * r + c];

            assign w_n = {3'b000, w_pad[P - 11]} + {3'b000, w_pad[P - 10]}
                       + {3'b000, w_pad[P - 9]}  + {3'b000, w_pad[P - 1]}
                       + {3'b000, w_pad[P + 1]}  + {3'b000, w_pad[P + 9]}
                       + {3'b000, w_pad[P + 10]} + {3'b000, w_pad[P + 11]};

            // Born on exactly 3; survives on 2 or 3.
            assign w_next[8 * r + c] = (w_n == 4'd3) |
                                       (r_grid[8 * r + c] & (w_n == 4'd2));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grid   <= '0;
            r_cursor <= '0;
        end else begin
            case (w_mode)
                MODE_EDIT: begin
                    if (btn0 ^ btn1) begin
                        r_grid[r_cursor] <= btn0;
                        r_cursor         <= r_cursor + 6'd1;
                    end
                end
                MODE_PLAY: begin
                    if (!stop) begin
                        r_grid <= w_next;
                    end
                end
                MODE_CLEAR: begin
                    r_grid   <= '0;
                    r_cursor <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_datapath.sv
// Testbench for life_datapath: directed scenarios with hand-computed boards.
module tb_life_datapath;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic        btn0;
    logic        btn1;
    logic        stop;
    logic [63:0] grid;

    int n_pass;
    int n_total;

    life_datapath u_dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .btn0 (btn0),
        .btn1 (btn1),
        .stop (stop),
        .grid (grid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs for n clocks, then settle 1 time unit past the last edge.
    task automatic drive(input logic r, input logic [1:0] m, input logic b0,
                         input logic b1, input logic s, input int n);
        rst  = r;
        mode = m;
        btn0 = b0;
        btn1 = b1;
        stop = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1);
        n_total++;
        if (grid !== 64'h0) $display("FAIL reset_initial: grid=%h expected=%h", grid, 64'h0);
        else n_pass++;

        drive(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 3);
        n_total++;
        if (grid !== 64'h7) $display("FAIL edit_after_reset: grid=%h expected=%h", grid, 64'h7);
        else n_pass++;

        drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1);
        n_total++;
        if (grid !== 64'h0) $display("FAIL reset_overrides_edit: grid=%h expected=%h", grid, 64'h0);
        else n_pass++;

        drive(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1);
        n_total++;
        if (grid !== 64'h1) $display("FAIL reset_cursor_zero: grid=%h expected=%h", grid, 64'h1);
        else n_pass++;
    endtask

    task automatic test_edit_sequence;
        drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1);
        drive(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2);
        drive(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1);
        drive(1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 5);
        drive(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1);
        drive(1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1);
        drive(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 2);
        drive(1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1);
        n_total++;
        if (grid !== 64'h341) $display("FAIL edit_sequence: grid=%h expected=%h", grid, 64'h341);
        else n_pass++;
    endtask

    task automatic test_play_block;
        drive(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1);
        n_total++;
        if (grid !== 64'h303) $display("FAIL block_formed: grid=%h expected=%h", grid, 64'h303);
        else n_pass++;

        // Buttons must be ignored in play.
        drive(1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 2);
        n_total++;
        if (grid !== 64'h303) $display("FAIL block_still_life: grid=%h expected=%h", grid, 64'h303);
        else n_pass++;

        // Cursor was 11 after the edit sequence and must survive play.
        drive(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1);
        n_total++;
        if (grid !== 64'hB03) $display("FAIL cursor_held_11: grid=%h expected=%h", grid, 64'hB03);
        else n_pass++;
    endtask

    task automatic test_blinker;
        drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1);
        n_total++;
        if (grid !== 64'h0) $display("FAIL clear_before_blinker: grid=%h expected=%h", grid, 64'h0);
        else n_pass++;

        // stop high during edit must not block writes.
        drive(1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 9);
        drive(1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 3);
        n_total++;
        if (grid !== 64'hE00) $display("FAIL blinker_load: grid=%h expected=%h", grid, 64'hE00);
        else n_pass++;

        drive(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1);
        n_total++;
        if (grid !== 64'h40404) $display("FAIL blinker_vertical: grid=%h expected=%h", grid, 64'h40404);
        else n_pass++;

        drive(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1);
        n_total++;
        if (grid !== 64'hE00) $display("FAIL blinker_horizontal: grid=%h expected=%h", grid, 64'hE00);
        else n_pass++;

        drive(1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 2);
        n_total++;
        if (grid !== 64'hE00) $display("FAIL play_stopped: grid=%h expected=%h", grid, 64'hE00);
        else n_pass++;

        drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2);
        n_total++;
        if (grid !== 64'hE00) $display("FAIL hold_mode: grid=%h expected=%h", grid, 64'hE00);
        else n_pass++;

        drive(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1);
        n_total++;
        if (grid !== 64'h1E00) $display("FAIL cursor_held_12: grid=%h expected=%h", grid, 64'h1E00);
        else n_pass++;
    endtask

    task automatic test_corner_and_both_buttons;
        drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1);
        drive(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1);
        n_total++;
        if (grid !== 64'h1) $display("FAIL corner_load: grid=%h expected=%h", grid, 64'h1);
        else n_pass++;

        drive(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1);
        n_total++;
        if (grid !== 64'h0) $display("FAIL corner_dies: grid=%h expected=%h", grid, 64'h0);
        else n_pass++;

        drive(1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2);
        n_total++;
        if (grid !== 64'h0) $display("FAIL both_buttons_no_write: grid=%h expected=%h", grid, 64'h0);
        else n_pass++;

        drive(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1);
        n_total++;
        if (grid !== 64'h2) $display("FAIL both_buttons_cursor_held: grid=%h expected=%h", grid, 64'h2);
        else n_pass++;
    endtask

    task automatic test_wrap_clear;
        drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1);
        drive(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 64);
        n_total++;
        if (grid !== 64'hFFFF_FFFF_FFFF_FFFF)
            $display("FAIL fill_all: grid=%h expected=%h", grid, 64'hFFFF_FFFF_FFFF_FFFF);
        else n_pass++;

        drive(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1);
        n_total++;
        if (grid !== 64'h8100_0000_0000_0081)
            $display("FAIL corners_survive: grid=%h expected=%h", grid, 64'h8100_0000_0000_0081);
        else n_pass++;

        // Cursor wrapped to 0, so the next write lands on cell 0.
        drive(1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1);
        n_total++;
        if (grid !== 64'h8100_0000_0000_0080)
            $display("FAIL cursor_wrapped: grid=%h expected=%h", grid, 64'h8100_0000_0000_0080);
        else n_pass++;

        drive(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1);
        n_total++;
        if (grid !== 64'h0) $display("FAIL clear_mode: grid=%h expected=%h", grid, 64'h0);
        else n_pass++;

        drive(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1);
        n_total++;
        if (grid !== 64'h1) $display("FAIL clear_cursor_zero: grid=%h expected=%h", grid, 64'h1);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst  = 1'b1;
        mode = 2'b00;
        btn0 = 1'b0;
        btn1 = 1'b0;
        stop = 1'b0;
        @(negedge clk);

        test_reset();
        test_edit_sequence();
        test_play_block();
        test_blinker();
        test_corner_and_both_buttons();
        test_wrap_clear();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
